// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRdata
  } state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-pin bundle for the RAM arbiter.
// slave: the arbiter side. master: requesters plus the RAM instance.
interface ram_arbiter_if;
  import ram_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wrt_en;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_wdata, ram_wrt_en
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_wdata, ram_wrt_en
  );

endinterface

// File: rtl/rr_pick.sv
// Two-way request picker returning a one-hot winner.
// RAM_ARB_RR_EN defined: pointer selects the winner on a tie (round-robin).
// RAM_ARB_RR_EN undefined: req0 always wins; the pointer is ignored.
module rr_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] win
);

`ifdef RAM_ARB_RR_EN
  // Tie broken by the pointer, otherwise the lone requester wins.
  always_comb begin
    win = 2'b00;
    if (req0 && req1) begin
      win = ptr ? 2'b10 : 2'b01;
    end else if (req0) begin
      win = 2'b01;
    end else if (req1) begin
      win = 2'b10;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;

  // Fixed priority: req0 over req1.
  always_comb begin
    win = 2'b00;
    if (req0) begin
      win = 2'b01;
    end else if (req1) begin
      win = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester access controller for the single-port 4K x 8 RAM.
// Optional round-robin arbitration is enabled by defining RAM_ARB_RR_EN;
// without it requester 0 has fixed priority.
module ram_arbiter
  import ram_arb_pkg::*;
(
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              owner_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic              ptr;
  logic [1:0]        win;

  rr_pick u_rr_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .ptr  (ptr),
    .win  (win)
  );

`ifdef RAM_ARB_RR_EN
  logic ptr_q;

  // After any grant the pointer favours the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (state_q == StIdle && win != 2'b00) begin
      ptr_q <= win[0];
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  // Access FSM with request latches and registered gnt/rvalid/rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      owner_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win != 2'b00) begin
            owner_q <= win[1];
            if (win[1]) begin
              we_q    <= bus.we1;
              addr_q  <= bus.addr1;
              wdata_q <= bus.wdata1;
            end else begin
              we_q    <= bus.we0;
              addr_q  <= bus.addr0;
              wdata_q <= bus.wdata0;
            end
            gnt0_q  <= win[0];
            gnt1_q  <= win[1];
            state_q <= StAccess;
          end
        end
        StAccess: begin
          state_q <= we_q ? StIdle : StRdata;
        end
        StRdata: begin
          // RAM output is registered, so the data is valid in this state.
          rdata_q   <= bus.ram_rdata;
          rvalid0_q <= ~owner_q;
          rvalid1_q <= owner_q;
          state_q   <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  // Reset gates the strobe directly so an interrupted access never writes.
  assign bus.ram_wrt_en = (state_q == StAccess) & we_q & ~rst;

endmodule
